// File: rtl/rvx_core_mdu_sequencer_pkg.sv
// Shared encodings and helpers for the Zmmul multiply sequencer and its shift-add datapath.
package rvx_core_mdu_sequencer_pkg;

  localparam logic [1:0] RVX_MDU_OP_MUL    = 2'b00;
  localparam logic [1:0] RVX_MDU_OP_MULH   = 2'b01;
  localparam logic [1:0] RVX_MDU_OP_MULHSU = 2'b10;
  localparam logic [1:0] RVX_MDU_OP_MULHU  = 2'b11;

  localparam logic [1:0] RVX_MDU_STATE_IDLE = 2'b00;
  localparam logic [1:0] RVX_MDU_STATE_RUN  = 2'b01;
  localparam logic [1:0] RVX_MDU_STATE_DONE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = RVX_MDU_STATE_IDLE,
    ST_RUN  = RVX_MDU_STATE_RUN,
    ST_DONE = RVX_MDU_STATE_DONE
  } mdu_state_e;

  // 0x80000000 stays 0x80000000, which read as unsigned is the required 2^31.
  function automatic logic [31:0] mdu_abs(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/rvx_core_mdu_shift_add.sv
// Unsigned shift-add multiplier datapath: consumes BITS_PER_CYCLE multiplier bits per step.
module rvx_core_mdu_shift_add #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        load_i,
  input  logic        step_i,
  input  logic [31:0] multiplicand_i,
  input  logic [31:0] multiplier_i,
  output logic [63:0] acc_o
);

  localparam int BPC = BITS_PER_CYCLE;

  logic [31:0]      mcand_q, mcand_d;
  logic [31:0]      mplier_q, mplier_d;
  logic [63:0]      acc_q, acc_d;
  logic [BPC-1:0]   digit;
  logic [31+BPC:0]  partial;
  logic [63+BPC:0]  sum;

  // Partial product lands on the upper half; the whole sum then shifts right,
  // so after all steps the accumulator holds the full 64-bit product.
  assign digit   = mplier_q[BPC-1:0];
  assign partial = {{BPC{1'b0}}, mcand_q} * {{32{1'b0}}, digit};
  assign sum     = {{BPC{1'b0}}, acc_q} + {partial, 32'b0};

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    if (load_i) begin
      mcand_d  = multiplicand_i;
      mplier_d = multiplier_i;
      acc_d    = 64'b0;
    end else if (step_i) begin
      mplier_d = {{BPC{1'b0}}, mplier_q[31:BPC]};
      acc_d    = sum[63+BPC:BPC];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mcand_q  <= 32'b0;
      mplier_q <= 32'b0;
      acc_q    <= 64'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/rvx_core_mdu_sequencer.sv
// Iterative MUL/MULH/MULHSU/MULHU controller: freezes the pipeline, runs the shift-add
// datapath for 32/BITS_PER_CYCLE cycles and returns the selected product half for one cycle.
module rvx_core_mdu_sequencer
  import rvx_core_mdu_sequencer_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start_s2,
  input  logic [1:0]  operation_s2,
  input  logic [31:0] rs1_data_s2,
  input  logic [31:0] rs2_data_s2,
  input  logic        flush,
  output logic        stall_request,
  output logic        result_valid,
  output logic [31:0] result
);

  localparam int ITERATIONS = 32 / BITS_PER_CYCLE;
  localparam int CNT_W      = $clog2(ITERATIONS) + 1;

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic             neg_q, neg_d;
  logic             accept, last_iter;
  logic             rs1_signed, rs2_signed;
  logic [63:0]      acc, product;

  assign accept     = (state_q == ST_IDLE) && start_s2 && !flush;
  assign last_iter  = (cnt_q == CNT_W'(ITERATIONS - 1));
  assign rs1_signed = (operation_s2 == RVX_MDU_OP_MULH) || (operation_s2 == RVX_MDU_OP_MULHSU);
  assign rs2_signed = (operation_s2 == RVX_MDU_OP_MULH);

  rvx_core_mdu_shift_add #(
    .BITS_PER_CYCLE(BITS_PER_CYCLE)
  ) u_shift_add (
    .clock          (clock),
    .reset_n        (reset_n),
    .load_i         (accept),
    .step_i         (state_q == ST_RUN),
    .multiplicand_i (mdu_abs(rs1_data_s2, rs1_signed)),
    .multiplier_i   (mdu_abs(rs2_data_s2, rs2_signed)),
    .acc_o          (acc)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= 2'b0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (start_s2) state_d = ST_RUN;
        ST_RUN:  if (last_iter) state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    op_d  = op_q;
    neg_d = neg_q;
    if (accept) begin
      cnt_d = '0;
      op_d  = operation_s2;
      neg_d = (rs1_signed & rs1_data_s2[31]) ^ (rs2_signed & rs2_data_s2[31]);
    end else if (state_q == ST_RUN) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Reset gating keeps every output at zero while reset_n is held low.
  assign product = neg_q ? (~acc + 64'd1) : acc;

  always_comb begin
    stall_request = reset_n && (accept || (state_q == ST_RUN));
    result_valid  = reset_n && (state_q == ST_DONE) && !flush;
    result        = 32'b0;
    if (result_valid) begin
      result = (op_q == RVX_MDU_OP_MUL) ? product[31:0] : product[63:32];
    end
  end

endmodule

// File: tb/tb_rvx_core_mdu_sequencer.sv
// Bench for rvx_core_mdu_sequencer: two instances (1 and 4 bits per cycle) on shared inputs.
module tb_rvx_core_mdu_sequencer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start_s2;
  logic [1:0]  operation_s2;
  logic [31:0] rs1_data_s2, rs2_data_s2;
  logic        flush;
  logic        stall1, valid1, stall4, valid4;
  logic [31:0] res1, res4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  rvx_core_mdu_sequencer #(.BITS_PER_CYCLE(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .start_s2(start_s2), .operation_s2(operation_s2),
    .rs1_data_s2(rs1_data_s2), .rs2_data_s2(rs2_data_s2), .flush(flush),
    .stall_request(stall1), .result_valid(valid1), .result(res1));

  rvx_core_mdu_sequencer #(.BITS_PER_CYCLE(4)) dut4 (
    .clock(clock), .reset_n(reset_n), .start_s2(start_s2), .operation_s2(operation_s2),
    .rs1_data_s2(rs1_data_s2), .rs2_data_s2(rs2_data_s2), .flush(flush),
    .stall_request(stall4), .result_valid(valid4), .result(res4));

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[6];

  // Architectural model: sign-extend per operation, take the exact 64-bit product.
  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [32:0] sa, sb;
    logic [65:0] p;
    sa = (op == 2'b01 || op == 2'b10) ? {a[31], a} : {1'b0, a};
    sb = (op == 2'b01) ? {b[31], b} : {1'b0, b};
    p  = {{33{sa[32]}}, sa} * {{33{sb[32]}}, sb};
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic quiesce();
    start_s2 = 1'b0;
    flush    = 1'b1;
    @(posedge clock); #1;
    flush    = 1'b0;
  endtask

  // Called at posedge+1; drives start, checks every cycle to DONE, returns at posedge+1
  // after DONE with start still high (caller chooses back-to-back or idle).
  task automatic run_op(input int sel, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input string name);
    int   lat;
    int   bad;
    logic st, vl;
    logic [31:0] rs;
    lat = (sel == 1) ? 33 : 9;
    bad = 0;
    start_s2     = 1'b1;
    operation_s2 = op;
    rs1_data_s2  = a;
    rs2_data_s2  = b;
    rs = 32'b0;
    for (int k = 0; k <= lat; k++) begin
      @(negedge clock);
      st = (sel == 1) ? stall1 : stall4;
      vl = (sel == 1) ? valid1 : valid4;
      rs = (sel == 1) ? res1 : res4;
      if (k < lat) begin
        if (st !== 1'b1 || vl !== 1'b0 || rs !== 32'b0) bad++;
        @(posedge clock); #1;
      end else begin
        if (st !== 1'b0 || vl !== 1'b1) bad++;
      end
    end
    check({name, "_timing"}, bad, 0);
    check({name, "_result"}, rs, exp);
    @(posedge clock); #1;
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    int          bad;

    vecs[0] = '{2'b00, 32'h0000_0007, 32'h0000_0006, 32'h0000_002A};
    vecs[1] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[2] = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    vecs[3] = '{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[4] = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[5] = '{2'b00, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE};

    reset_n = 1'b0; start_s2 = 1'b1; flush = 1'b0;
    operation_s2 = 2'b00; rs1_data_s2 = 32'd1; rs2_data_s2 = 32'd1;
    #3;
    check("reset_stall", {31'b0, stall1}, 32'd0);
    check("reset_valid", {31'b0, valid1}, 32'd0);
    check("reset_result", res1, 32'd0);
    start_s2 = 1'b0;
    @(posedge clock); @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;

    for (int i = 0; i < 6; i++) begin
      quiesce();
      run_op(1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d_b1", i));
      quiesce();
      run_op(4, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d_b4", i));
    end

    for (int i = 0; i < 16; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = (i % 4 == 0) ? 32'h8000_0000 : $urandom;
      rb  = (i % 5 == 0) ? 32'h8000_0000 : $urandom;
      quiesce();
      run_op((i % 2 == 0) ? 1 : 4, rop, ra, rb, ref_mul(rop, ra, rb), $sformatf("rand%0d", i));
    end

    // Flush in RUN cycle 10: no result must ever appear for the killed op.
    quiesce();
    start_s2 = 1'b1; operation_s2 = 2'b00; rs1_data_s2 = 32'd7; rs2_data_s2 = 32'd7;
    for (int k = 0; k < 10; k++) begin
      @(posedge clock); #1;
    end
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0; start_s2 = 1'b0;
    @(negedge clock);
    check("flush_stall", {31'b0, stall1}, 32'd0);
    check("flush_valid", {31'b0, valid1}, 32'd0);
    bad = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clock);
      if (valid1 !== 1'b0 || stall1 !== 1'b0) bad++;
    end
    check("flush_quiet", bad, 0);
    @(posedge clock); #1;
    run_op(1, 2'b00, 32'd3, 32'd5, 32'h0000_000F, "after_flush");

    // Asynchronous reset in the middle of RUN.
    quiesce();
    start_s2 = 1'b1; operation_s2 = 2'b00; rs1_data_s2 = 32'h1234; rs2_data_s2 = 32'h5678;
    for (int k = 0; k < 5; k++) begin
      @(posedge clock); #1;
    end
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_stall", {31'b0, stall1}, 32'd0);
    check("arst_valid", {31'b0, valid1}, 32'd0);
    check("arst_result", res1, 32'd0);
    start_s2 = 1'b0;
    @(posedge clock); #3;
    reset_n = 1'b1;
    @(posedge clock); #1;
    run_op(1, 2'b11, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, "after_reset");

    // Back-to-back on the 4-bit instance: results at cycles 9 and 19.
    quiesce();
    run_op(4, 2'b00, 32'd2, 32'd3, 32'd6, "b2b_first");
    run_op(4, 2'b00, 32'd4, 32'd5, 32'd20, "b2b_second");
    start_s2 = 1'b0;
    @(negedge clock);
    check("b2b_single_valid", {31'b0, valid4}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
